melody_sequencer_ctrl: RTL and testbench

//  Playback controller for the tone datapath. Walks an external score ROM (note index + duration per step),

---
 rtl/melody_sequencer_ctrl.sv | 174 +++++++++++++++++
 tb/tb_melody_sequencer_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/melody_sequencer_ctrl.sv
// Score-ROM playback controller: start/stop/loop, rests, per-step duration and articulation gap.
// Optional pause input is compiled in with `define SEQCTRL_PAUSE_EN.
module melody_sequencer_ctrl #(
  parameter int IDX_BW    = 6,
  parameter int SEQ_LEN   = 64,
  parameter int DUR_BW    = 4,
  parameter int GAP_TICKS = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              strb_i,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic              loop_i,
  input  logic              pause_i,
  input  logic [IDX_BW-1:0] step_note_i,
  input  logic [DUR_BW-1:0] step_dur_i,
  output logic [IDX_BW-1:0] step_addr_o,
  output logic [IDX_BW-1:0] note_index_o,
  output logic              tone_en_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int GAP_BW = (GAP_TICKS < 2) ? 1 : $clog2(GAP_TICKS + 1);
  localparam logic [IDX_BW-1:0] LAST_ADDR = IDX_BW'(SEQ_LEN - 1);
  localparam logic [GAP_BW-1:0] GAP_INIT  = GAP_BW'(GAP_TICKS);

  typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;

  state_t            state_reg, state_next;
  logic [IDX_BW-1:0] addr_reg, addr_next;
  logic [IDX_BW-1:0] note_reg, note_next;
  logic [DUR_BW-1:0] dur_reg, dur_next;
  logic [GAP_BW-1:0] gap_reg, gap_next;
  logic              tone_reg, tone_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;

  logic pause_mute;
  logic tick;
  logic at_last;

`ifdef SEQCTRL_PAUSE_EN
  assign pause_mute = pause_i;
`else
  logic unused_pause;
  assign unused_pause = pause_i;
  assign pause_mute   = 1'b0;
`endif

  // A paused strobe is simply not a strobe for PLAY/GAP; LOAD ignores strobes anyway.
  assign tick    = strb_i & ~pause_mute;
  assign at_last = (addr_reg == LAST_ADDR);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      note_reg  <= '0;
      dur_reg   <= '0;
      gap_reg   <= '0;
      tone_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      note_reg  <= note_next;
      dur_reg   <= dur_next;
      gap_reg   <= gap_next;
      tone_reg  <= tone_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (stop_i) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: if (start_i) state_next = LOAD;
        LOAD: begin
          if (step_dur_i != '0)
            state_next = PLAY;
          else if (!(loop_i && addr_reg != '0))
            state_next = IDLE;
        end
        PLAY: begin
          if (tick && dur_reg == DUR_BW'(1)) begin
            if (GAP_TICKS != 0)
              state_next = GAP;
            else
              state_next = (at_last && !loop_i) ? IDLE : LOAD;
          end
        end
        GAP: begin
          if (tick && gap_reg == GAP_BW'(1))
            state_next = (at_last && !loop_i) ? IDLE : LOAD;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    addr_next = addr_reg;
    note_next = note_reg;
    dur_next  = dur_reg;
    gap_next  = gap_reg;
    done_next = 1'b0;
    if (stop_i) begin
      addr_next = '0;
      note_next = '0;
      dur_next  = '0;
      gap_next  = '0;
    end else begin
      case (state_reg)
        IDLE: if (start_i) addr_next = '0;
        LOAD: begin
          if (step_dur_i != '0) begin
            note_next = step_note_i;
            dur_next  = step_dur_i;
          end else if (loop_i && addr_reg != '0) begin
            addr_next = '0;
          end else begin
            done_next = 1'b1;
          end
        end
        PLAY: begin
          if (tick) begin
            dur_next = dur_reg - 1'b1;
            if (dur_reg == DUR_BW'(1)) begin
              if (GAP_TICKS != 0) begin
                gap_next = GAP_INIT;
              end else if (at_last) begin
                if (loop_i) addr_next = '0;
                else        done_next = 1'b1;
              end else begin
                addr_next = addr_reg + 1'b1;
              end
            end
          end
        end
        GAP: begin
          if (tick) begin
            gap_next = gap_reg - 1'b1;
            if (gap_reg == GAP_BW'(1)) begin
              if (at_last) begin
                if (loop_i) addr_next = '0;
                else        done_next = 1'b1;
              end else begin
                addr_next = addr_reg + 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
    // Outputs are registered, so derive them from the state being entered.
    tone_next = (state_next == PLAY) && (note_next != '0) && !pause_mute;
    busy_next = (state_next != IDLE);
  end

  assign step_addr_o  = addr_reg;
  assign note_index_o = note_reg;
  assign tone_en_o    = tone_reg;
  assign busy_o       = busy_reg;
  assign done_o       = done_reg;

endmodule

// File: tb/tb_melody_sequencer_ctrl.sv
// Directed bench for melody_sequencer_ctrl: score ROM model, hand-derived expected outputs per cycle.
module tb_melody_sequencer_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       strb_i = 1'b0, start_i = 1'b0, stop_i = 1'b0, loop_i = 1'b0, pause_i = 1'b0;
  logic [5:0] step_note_i;
  logic [3:0] step_dur_i;
  logic [5:0] step_addr_o, note_index_o;
  logic       tone_en_o, busy_o, done_o;

  logic [5:0] score_note [64];
  logic [3:0] score_dur  [64];
  int n_checks = 0;
  int n_errors = 0;
  int done_seen = 0;

  melody_sequencer_ctrl #(.IDX_BW(6), .SEQ_LEN(64), .DUR_BW(4), .GAP_TICKS(1)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .strb_i(strb_i), .start_i(start_i), .stop_i(stop_i),
    .loop_i(loop_i), .pause_i(pause_i), .step_note_i(step_note_i), .step_dur_i(step_dur_i),
    .step_addr_o(step_addr_o), .note_index_o(note_index_o), .tone_en_o(tone_en_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  always_comb begin
    step_note_i = score_note[step_addr_o];
    step_dur_i  = score_dur[step_addr_o];
  end

  always @(posedge clk_i) if (done_o) done_seen <= done_seen + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic strobe();
    strb_i = 1'b1;
    tick();
    strb_i = 1'b0;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic load_test_score();
    for (int i = 0; i < 64; i++) begin
      score_note[i] = 6'd0;
      score_dur[i]  = 4'd0;
    end
    score_note[0] = 6'd5; score_dur[0] = 4'd2;
    score_note[1] = 6'd0; score_dur[1] = 4'd1;
    score_note[2] = 6'd9; score_dur[2] = 4'd1;
    score_note[3] = 6'd7; score_dur[3] = 4'd0;
  endtask

  task automatic expect_out(input string tag, input int tone, input int busy, input int addr);
    check({tag, ".tone"}, 32'(tone_en_o), 32'(tone));
    check({tag, ".busy"}, 32'(busy_o), 32'(busy));
    check({tag, ".addr"}, 32'(step_addr_o), 32'(addr));
  endtask

  initial begin
    int d0;
    load_test_score();
    tick(); tick();
    check("rst.addr", 32'(step_addr_o), 0);
    check("rst.note", 32'(note_index_o), 0);
    check("rst.tone", 32'(tone_en_o), 0);
    check("rst.busy", 32'(busy_o), 0);
    check("rst.done", 32'(done_o), 0);
    rst_i = 1'b0;
    tick();

    // Test 2: one-shot playback with rests and gaps.
    d0 = done_seen;
    pulse_start();
    expect_out("t2.load0", 0, 1, 0);
    tick();
    expect_out("t2.play5", 1, 1, 0);
    check("t2.note5", 32'(note_index_o), 5);
    start_i = 1'b1; tick(); start_i = 1'b0;
    expect_out("t2.start_ignored", 1, 1, 0);
    strobe();
    expect_out("t2.play5b", 1, 1, 0);
    tick();
    expect_out("t2.nostrb", 1, 1, 0);
    strobe();
    expect_out("t2.gap0", 0, 1, 0);
    strobe();
    expect_out("t2.load1", 0, 1, 1);
    tick();
    expect_out("t2.rest", 0, 1, 1);
    check("t2.restnote", 32'(note_index_o), 0);
    strobe();
    expect_out("t2.gap1", 0, 1, 1);
    strobe();
    expect_out("t2.load2", 0, 1, 2);
    tick();
    expect_out("t2.play9", 1, 1, 2);
    check("t2.note9", 32'(note_index_o), 9);
    strobe();
    expect_out("t2.gap2", 0, 1, 2);
    strobe();
    expect_out("t2.load3", 0, 1, 3);
    tick();
    check("t2.done", 32'(done_o), 1);
    check("t2.busy_fall", 32'(busy_o), 0);
    tick();
    check("t2.done_pulse", 32'(done_o), 0);
    check("t2.done_once", 32'(done_seen - d0), 1);

    // Test 3: loop back from end marker.
    d0 = done_seen;
    loop_i = 1'b1;
    pulse_start();
    tick();
    strobe(); strobe(); strobe();           // note 5 (2 strobes) then gap
    tick(); strobe(); strobe();             // rest + gap
    tick(); strobe(); strobe();             // note 9 + gap
    expect_out("t3.load3", 0, 1, 3);
    tick();
    expect_out("t3.wrap", 0, 1, 0);
    tick();
    expect_out("t3.replay", 1, 1, 0);
    check("t3.note5", 32'(note_index_o), 5);
    check("t3.nodone", 32'(done_seen - d0), 0);

    // Test 5: stop with strobe mid-note, then start+stop together.
    stop_i = 1'b1; strb_i = 1'b1; tick(); stop_i = 1'b0; strb_i = 1'b0;
    expect_out("t5.stop", 0, 0, 0);
    check("t5.note", 32'(note_index_o), 0);
    check("t5.nodone", 32'(done_seen - d0), 0);
    loop_i = 1'b0;
    start_i = 1'b1; stop_i = 1'b1; tick(); start_i = 1'b0; stop_i = 1'b0;
    check("t5.startstop", 32'(busy_o), 0);
    tick();
    check("t5.stillidle", 32'(busy_o), 0);

    // Test 1: reset held two cycles mid-PLAY.
    pulse_start(); tick();
    check("t1.playing", 32'(tone_en_o), 1);
    rst_i = 1'b1; tick(); tick(); rst_i = 1'b0;
    expect_out("t1.rst", 0, 0, 0);
    check("t1.note", 32'(note_index_o), 0);
    strobe();
    expect_out("t1.strb_after", 0, 0, 0);

    // Test 4: full 64-step score without end marker.
    for (int i = 0; i < 64; i++) begin
      score_note[i] = 6'((i % 63) + 1);
      score_dur[i]  = 4'd1;
    end
    d0 = done_seen;
    pulse_start();
    for (int i = 0; i < 64; i++) begin
      tick();
      if (i == 0 || i == 62 || i == 63) begin
        expect_out($sformatf("t4.play%0d", i), 1, 1, i);
        check($sformatf("t4.note%0d", i), 32'(note_index_o), 32'((i % 63) + 1));
      end
      strobe(); strobe();
    end
    check("t4.done", 32'(done_o), 1);
    check("t4.busy", 32'(busy_o), 0);
    check("t4.nowrap", 32'(step_addr_o), 63);
    tick();
    check("t4.done_once", 32'(done_seen - d0), 1);

`ifdef SEQCTRL_PAUSE_EN
    // Test 6: pause freezes the remaining duration.
    for (int i = 0; i < 64; i++) begin
      score_note[i] = 6'd0;
      score_dur[i]  = 4'd0;
    end
    score_note[0] = 6'd12; score_dur[0] = 4'd4;
    pulse_start(); tick();
    strobe();
    check("t6.before", 32'(tone_en_o), 1);
    pause_i = 1'b1;
    tick();
    check("t6.muted", 32'(tone_en_o), 0);
    for (int i = 0; i < 10; i++) begin
      strobe();
      check("t6.paused", 32'(tone_en_o), 0);
    end
    pause_i = 1'b0;
    tick();
    check("t6.resume", 32'(tone_en_o), 1);
    strobe(); check("t6.rem2", 32'(tone_en_o), 1);
    strobe(); check("t6.rem1", 32'(tone_en_o), 1);
    strobe(); check("t6.end", 32'(tone_en_o), 0);
    check("t6.busy", 32'(busy_o), 1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
